// File: rtl/hs32_regfile_banked.sv
// Banked multi-read-port register file: shared low registers, per-bank high registers,
// synchronous write-first reads, and a sequencer that zeroes every entry after reset or clr.
module hs32_regfile_banked #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2,
    parameter int NBANKS     = 2,
    parameter int SHARED     = 12,
    localparam int BW        = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clr,
    output logic                           ready,
    input  logic [BW-1:0]                  bank,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          wadr,
    input  logic [DATA_WIDTH-1:0]          din,
    input  logic [NREAD*ADDR_WIDTH-1:0]    radr,
    output logic [NREAD*DATA_WIDTH-1:0]    dout
);
    localparam int NREGS  = 2 ** ADDR_WIDTH;
    localparam int BANKED = NREGS - SHARED;
    localparam int P      = SHARED + NBANKS * BANKED;
    localparam int CW     = (P > 1) ? $clog2(P) : 1;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           c_reg, c_next;
    logic                    wr_en, bypass_en, rd_zero;
    logic [CW-1:0]           wr_idx;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   mem [P];
    logic [DATA_WIDTH-1:0]   dout_reg [NREAD];

    // Out-of-range banks fold onto bank 0 so every address maps to a real entry.
    function automatic logic [CW-1:0] phys(input logic [ADDR_WIDTH-1:0] a, input logic [BW-1:0] b);
        int bi;
        int idx;
        bi = (int'(b) < NBANKS) ? int'(b) : 0;
        if (int'(a) < SHARED)
            idx = int'(a);
        else
            idx = SHARED + bi * BANKED + int'(a) - SHARED;
        return CW'(idx);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_CLEAR;
            c_reg     <= '0;
        end else begin
            state_reg <= state_next;
            c_reg     <= c_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        c_next     = c_reg;
        case (state_reg)
            ST_CLEAR: begin
                if (int'(c_reg) == P - 1) begin
                    state_next = ST_READY;
                    c_next     = '0;
                end else begin
                    c_next = c_reg + 1'b1;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                    c_next     = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                c_next     = '0;
            end
        endcase
    end

    // clr wins over a same-cycle write and zeroes that edge's read data.
    always_comb begin
        ready     = (state_reg == ST_READY);
        wr_en     = 1'b0;
        wr_idx    = phys(wadr, bank);
        wr_data   = din;
        bypass_en = 1'b0;
        rd_zero   = 1'b1;
        if (state_reg == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = c_reg;
            wr_data = '0;
        end else begin
            wr_en     = we & ~clr;
            bypass_en = we & ~clr;
            rd_zero   = clr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
    end

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [CW-1:0] rd_idx;
            assign rd_idx = phys(radr[gi*ADDR_WIDTH +: ADDR_WIDTH], bank);

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    dout_reg[gi] <= '0;
                else if (rd_zero)
                    dout_reg[gi] <= '0;
                else if (bypass_en && (rd_idx == wr_idx))
                    dout_reg[gi] <= din;
                else
                    dout_reg[gi] <= mem[rd_idx];
            end
        end
    endgenerate

    always_comb begin
        dout = '0;
        for (int k = 0; k < NREAD; k++)
            dout[k*DATA_WIDTH +: DATA_WIDTH] = dout_reg[k];
    end
endmodule

// File: tb/tb_hs32_regfile_banked.sv
// Directed bench for hs32_regfile_banked with default parameters (P = 20).
module tb_hs32_regfile_banked;
    localparam int P = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        ready;
    logic [0:0]  bank = '0;
    logic        we = 1'b0;
    logic [3:0]  wadr = '0;
    logic [31:0] din = '0;
    logic [7:0]  radr = '0;
    logic [63:0] dout;

    int n_checks = 0;
    int n_fail   = 0;

    hs32_regfile_banked dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .ready (ready),
        .bank  (bank),
        .we    (we),
        .wadr  (wadr),
        .din   (din),
        .radr  (radr),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  wadr;
        logic [31:0] din;
        logic [0:0]  bank;
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready must rise, checking it stays low for exactly P-1 edges.
    task automatic check_clear_run(input string name, input int first, input bit poke_clr);
        for (int i = first; i <= P; i++) begin
            clr = (poke_clr && i == 5);
            step();
            clr = 1'b0;
            chk($sformatf("%s_ready_e%0d", name, i), {31'd0, ready}, {31'd0, (i >= P)});
            if (i < P)
                chk($sformatf("%s_dout_e%0d", name, i), dout[31:0] | dout[63:32], 32'd0);
        end
    endtask

    task automatic check_all_zero(input string name);
        we = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 16; a++) begin
                bank = b[0:0];
                radr = {a[3:0], a[3:0]};
                step();
                chk($sformatf("%s_b%0d_r%0d_p0", name, b, a), dout[31:0], 32'd0);
                chk($sformatf("%s_b%0d_r%0d_p1", name, b, a), dout[63:32], 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'd13, 32'hDEADBEEF, 1'b0, 4'd13, 4'd1,  32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 4'd13, 32'h12345678, 1'b1, 4'd13, 4'd13, 32'h12345678, 32'h12345678};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd13, 4'd13, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd13, 4'd12, 32'h12345678, 32'h0};
        vecs[4]  = '{1'b1, 4'd3,  32'hA5A5A5A5, 1'b1, 4'd3,  4'd13, 32'hA5A5A5A5, 32'h12345678};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd3,  4'd13, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 4'd5,  32'h00000011, 1'b0, 4'd5,  4'd5,  32'h11,       32'h11};
        vecs[7]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd5,  4'd5,  32'h11,       32'h11};
        vecs[8]  = '{1'b1, 4'd14, 32'hCAFEF00D, 1'b0, 4'd14, 4'd15, 32'hCAFEF00D, 32'h0};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd14, 4'd14, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 4'd15, 32'h0BADC0DE, 1'b0, 4'd14, 4'd6,  32'hCAFEF00D, 32'h0};
        vecs[11] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd15, 4'd14, 32'h0BADC0DE, 32'hCAFEF00D};
        vecs[12] = '{1'b1, 4'd15, 32'h00000077, 1'b1, 4'd15, 4'd3,  32'h77,       32'hA5A5A5A5};
        vecs[13] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd15, 4'd0,  32'h0BADC0DE, 32'h0};

        // Reset state and initial clear run.
        #12;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_dout", dout[31:0] | dout[63:32], 32'd0);
        step();
        reset = 1'b0;
        check_clear_run("init", 1, 1'b0);
        check_all_zero("init_zero");

        // Table-driven READY traffic.
        for (int i = 0; i < 14; i++) begin
            we = vecs[i].we; wadr = vecs[i].wadr; din = vecs[i].din;
            bank = vecs[i].bank; radr = {vecs[i].r1, vecs[i].r0};
            step();
            $display("vec %0d: we=%0d wadr=%0d din=%h bank=%0d radr={%0d,%0d} -> dout={%h,%h}",
                     i, vecs[i].we, vecs[i].wadr, vecs[i].din, vecs[i].bank,
                     vecs[i].r1, vecs[i].r0, dout[63:32], dout[31:0]);
            chk($sformatf("vec%0d_p0", i), dout[31:0], vecs[i].e0);
            chk($sformatf("vec%0d_p1", i), dout[63:32], vecs[i].e1);
            chk($sformatf("vec%0d_ready", i), {31'd0, ready}, 32'd1);
        end
        we = 1'b0;

        // clr with a simultaneous write: write dropped, dout zeroed, clr mid-clear ignored.
        clr = 1'b1; we = 1'b1; wadr = 4'd13; din = 32'hFFFFFFFF; bank = 1'b0; radr = {4'd3, 4'd13};
        step();
        clr = 1'b0; we = 1'b0;
        $display("clr+we: ready=%0d dout={%h,%h}", ready, dout[63:32], dout[31:0]);
        chk("clr_ready", {31'd0, ready}, 32'd0);
        chk("clr_dout_p0", dout[31:0], 32'd0);
        chk("clr_dout_p1", dout[63:32], 32'd0);
        check_clear_run("clr", 1, 1'b1);
        check_all_zero("clr_zero");

        // Async reset mid-operation clears dout immediately.
        we = 1'b1; wadr = 4'd3; din = 32'h5A5A0001; bank = 1'b0; radr = {4'd3, 4'd3};
        step();
        we = 1'b0;
        chk("preload_p0", dout[31:0], 32'h5A5A0001);
        #2 reset = 1'b1;
        #1;
        $display("async reset mid-op: ready=%0d dout={%h,%h}", ready, dout[63:32], dout[31:0]);
        chk("async_rst_dout", dout[31:0] | dout[63:32], 32'd0);
        chk("async_rst_ready", {31'd0, ready}, 32'd0);
        step();
        reset = 1'b0;
        check_clear_run("rst_op", 1, 1'b0);

        // Reset at clear cycle 7 restarts the sequence from zero.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        #1;
        chk("midclr_rst_ready", {31'd0, ready}, 32'd0);
        step();
        step();
        reset = 1'b0;
        $display("reset released after mid-clear abort");
        check_clear_run("midclr", 1, 1'b0);
        check_all_zero("final_zero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
